store_drain_ctrl: RTL and testbench
===================================

Name: store_drain_ctrl

Overview:
Consumer end of the store buffer's L1-D interface. It takes the retired head store (head_valid/head_addr/head_data) and issues it to the L1-D cache write port with a request/grant/done handshake. It pulses pop_head exactly once per completed write, so the store buffer advances its head. Sits between the store buffer and the L1-D cache in the writeback/retire stage.

Parameters:
ADDR_W, 16, store address width
DATA_W, 16, store data width
TIMEOUT, 64, cycles to wait in WAIT for dc_wr_done before reissuing the request
CNT_W, 16, width of statistics counters

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous reset, active high
head_valid  in  1  store buffer head is valid, executed and retired
head_addr  in  ADDR_W  head store address
head_data  in  DATA_W  head store data
hold  in  1  drain stall (fence/flush); blocks new issues only
pop_head  out  1  one-cycle pulse: head has been written to the cache
dc_wr_req  out  1  write request to the L1-D cache
dc_wr_addr  out  ADDR_W  latched write address
dc_wr_data  out  DATA_W  latched write data
dc_wr_gnt  in  1  cache accepts the request this cycle (deasserted while a load owns the port)
dc_wr_done  in  1  write is complete; may coincide with gnt or arrive later
drain_idle  out  1  FSM in IDLE and no request outstanding
store_count  out  CNT_W  stores completed (wraps)
retry_count  out  CNT_W  timeout reissues (saturates at all-ones)

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active high.
- Reset values: state=IDLE, pop_head=0, dc_wr_req=0, dc_wr_addr=0, dc_wr_data=0, drain_idle=1, store_count=0, retry_count=0, timer=0.
- States: IDLE, REQ, WAIT, POP. Encoding comes from the package.
- IDLE: if head_valid && !hold, latch head_addr/head_data into dc_wr_addr/dc_wr_data and go to REQ. Otherwise stay.
- REQ: dc_wr_req=1.
  - dc_wr_gnt && dc_wr_done → POP.
  - dc_wr_gnt && !dc_wr_done → WAIT, with timer cleared.
  - No gnt → stay in REQ; address and data held stable.
- WAIT: dc_wr_req=0; timer increments each cycle.
  - dc_wr_done → POP.
  - timer==TIMEOUT-1 without done → REQ (reissue); retry_count+1, saturating.
  - A done arriving in the same cycle as the timeout wins: go to POP, no retry.
- POP: pop_head=1 for exactly this cycle; store_count+1 (mod 2^CNT_W); always go to IDLE.
  - Never chain directly from POP into a new issue: head_* is stale until the store buffer updates on this edge.
- Throughput: at most one store per 3 cycles.
  - Best case: head_valid seen in IDLE at cycle t, req at t+1 with gnt+done, pop at t+2, IDLE at t+3.
- hold: sampled only in IDLE. An in-flight store (REQ/WAIT/POP) always completes.
- head_valid or head_* changing after the latch (REQ/WAIT) is ignored; the latched values are used.
- pop_head is never asserted outside POP, and never asserted twice for one latched store.
- dc_wr_gnt/dc_wr_done outside their relevant states are ignored. A done in IDLE or REQ without gnt produces no pop.
- drain_idle = (state==IDLE). Registered-state decode, no combinational path from inputs.
- RST mid-operation (REQ/WAIT/POP): return to IDLE next edge, no pop pulse, req dropped, counters cleared.
- All outputs are derived from registered state. No combinational input→output paths.

Decomposition:
- Shared package: state enum (IDLE/REQ/WAIT/POP), ADDR_W/DATA_W defaults, TIMEOUT default.
- Single flat module; the timer and counters are small enough inline.
- No sub-module.

Test Plan:
- Single store, immediate ack: head_valid=1, addr=0x0040, data=0xBEEF, gnt=done=1 → dc_wr_req at cycle 1 with 0x0040/0xBEEF, pop_head high only at cycle 2, store_count=1.
- Grant delayed: gnt held 0 for 3 cycles then gnt=1, done 2 cycles later → req high 4 cycles, addr/data stable, one pop, drain_idle=0 throughout.
- Timeout: TIMEOUT=4, gnt=1, done never → reissue every 4 WAIT cycles, retry_count increments 1,2,3. Then done=1 → single pop.
- Back-to-back: three stores 0x10/0x11/0x12 with instant ack → pops 3 cycles apart, in order, store_count=3, no double pop.
- hold=1 with head_valid=1 for 5 cycles → no req. Assert hold during WAIT → the store still completes and pops.
- RST asserted in WAIT → next cycle IDLE, dc_wr_req=0, no pop, store_count=0, drain_idle=1.

Source files
------------

// File: rtl/store_drain_ctrl_pkg.sv
// Shared types and default sizing for the store-buffer drain controller.
package store_drain_ctrl_pkg;

  localparam int SDC_ADDR_W  = 16;
  localparam int SDC_DATA_W  = 16;
  localparam int SDC_TIMEOUT = 64;
  localparam int SDC_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_POP  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/store_drain_ctrl.sv
// Drains the retired store-buffer head into the L1-D write port (req/gnt/done), one pop per write.
// Best case 3 cycles per store; holds req with stable addr/data until gnt, reissues after TIMEOUT idle WAIT cycles.
module store_drain_ctrl
  import store_drain_ctrl_pkg::*;
#(
  parameter int ADDR_W  = SDC_ADDR_W,
  parameter int DATA_W  = SDC_DATA_W,
  parameter int TIMEOUT = SDC_TIMEOUT,
  parameter int CNT_W   = SDC_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              head_valid,
  input  logic [ADDR_W-1:0] head_addr,
  input  logic [DATA_W-1:0] head_data,
  input  logic              hold,
  output logic              pop_head,
  output logic              dc_wr_req,
  output logic [ADDR_W-1:0] dc_wr_addr,
  output logic [DATA_W-1:0] dc_wr_data,
  input  logic              dc_wr_gnt,
  input  logic              dc_wr_done,
  output logic              drain_idle,
  output logic [CNT_W-1:0]  store_count,
  output logic [CNT_W-1:0]  retry_count
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  drain_state_e      state_q;
  logic              pop_q;
  logic              req_q;
  logic              idle_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  store_cnt_q;
  logic [CNT_W-1:0]  retry_cnt_q;
  logic [TMR_W-1:0]  timer_q;

  // Every output is a register updated alongside the state, so no input reaches an output combinationally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      pop_q       <= 1'b0;
      req_q       <= 1'b0;
      idle_q      <= 1'b1;
      addr_q      <= '0;
      data_q      <= '0;
      store_cnt_q <= '0;
      retry_cnt_q <= '0;
      timer_q     <= '0;
    end else begin
      pop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (head_valid && !hold) begin
            addr_q  <= head_addr;
            data_q  <= head_data;
            req_q   <= 1'b1;
            idle_q  <= 1'b0;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dc_wr_gnt) begin
            req_q <= 1'b0;
            if (dc_wr_done) begin
              pop_q       <= 1'b1;
              store_cnt_q <= store_cnt_q + 1'b1;
              state_q     <= ST_POP;
            end else begin
              timer_q <= '0;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // done beats a coincident timeout: the write finished, so no reissue.
          if (dc_wr_done) begin
            pop_q       <= 1'b1;
            store_cnt_q <= store_cnt_q + 1'b1;
            state_q     <= ST_POP;
          end else if (timer_q == TMR_LAST) begin
            req_q   <= 1'b1;
            state_q <= ST_REQ;
            if (~&retry_cnt_q) retry_cnt_q <= retry_cnt_q + 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_POP: begin
          // Head is stale this cycle; always pass through IDLE before the next issue.
          idle_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pop_head    = pop_q;
  assign dc_wr_req   = req_q;
  assign dc_wr_addr  = addr_q;
  assign dc_wr_data  = data_q;
  assign drain_idle  = idle_q;
  assign store_count = store_cnt_q;
  assign retry_count = retry_cnt_q;

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Directed bench for store_drain_ctrl with TIMEOUT=4; inputs change and outputs are sampled 1ns after each rising edge.
module tb_store_drain_ctrl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          head_valid;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          hold;
  logic          pop_head;
  logic          dc_wr_req;
  logic [AW-1:0] dc_wr_addr;
  logic [DW-1:0] dc_wr_data;
  logic          dc_wr_gnt;
  logic          dc_wr_done;
  logic          drain_idle;
  logic [CW-1:0] store_count;
  logic [CW-1:0] retry_count;

  int n_tests = 0;
  int n_failed = 0;

  always #5 CLK = ~CLK;

  store_drain_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(4),
    .CNT_W  (CW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .hold       (hold),
    .pop_head   (pop_head),
    .dc_wr_req  (dc_wr_req),
    .dc_wr_addr (dc_wr_addr),
    .dc_wr_data (dc_wr_data),
    .dc_wr_gnt  (dc_wr_gnt),
    .dc_wr_done (dc_wr_done),
    .drain_idle (drain_idle),
    .store_count(store_count),
    .retry_count(retry_count)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1; head_valid = 1'b0; head_addr = '0; head_data = '0;
    hold = 1'b0; dc_wr_gnt = 1'b0; dc_wr_done = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_req", 32'(dc_wr_req), 0);
    chk("rst_pop", 32'(pop_head), 0);
    chk("rst_addr", 32'(dc_wr_addr), 0);
    chk("rst_data", 32'(dc_wr_data), 0);
    chk("rst_idle", 32'(drain_idle), 1);
    chk("rst_scnt", 32'(store_count), 0);
    chk("rst_rcnt", 32'(retry_count), 0);
    RST = 1'b0;
    tick();

    // Done in IDLE with no store pending produces nothing
    dc_wr_done = 1'b1; dc_wr_gnt = 1'b1;
    tick(); tick();
    chk("idle_done_pop", 32'(pop_head), 0);
    chk("idle_done_req", 32'(dc_wr_req), 0);

    // Single store, immediate ack
    head_valid = 1'b1; head_addr = 16'h0040; head_data = 16'hBEEF;
    tick();
    chk("t1_req", 32'(dc_wr_req), 1);
    chk("t1_addr", 32'(dc_wr_addr), 32'h0040);
    chk("t1_data", 32'(dc_wr_data), 32'hBEEF);
    chk("t1_pop_c1", 32'(pop_head), 0);
    chk("t1_idle_c1", 32'(drain_idle), 0);
    head_valid = 1'b0;
    tick();
    chk("t1_pop_c2", 32'(pop_head), 1);
    chk("t1_req_c2", 32'(dc_wr_req), 0);
    chk("t1_scnt", 32'(store_count), 1);
    tick();
    chk("t1_pop_c3", 32'(pop_head), 0);
    chk("t1_idle_c3", 32'(drain_idle), 1);
    chk("t1_scnt_c3", 32'(store_count), 1);

    // Grant delayed 3 cycles; done without gnt in REQ is ignored; head changes after latch ignored
    dc_wr_gnt = 1'b0; dc_wr_done = 1'b0;
    head_valid = 1'b1; head_addr = 16'h1234; head_data = 16'h5678;
    tick();
    head_valid = 1'b0; head_addr = 16'hFFFF; head_data = 16'h0000;
    dc_wr_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_req", 32'(dc_wr_req), 1);
      chk("t2_addr", 32'(dc_wr_addr), 32'h1234);
      chk("t2_data", 32'(dc_wr_data), 32'h5678);
      chk("t2_idle", 32'(drain_idle), 0);
      chk("t2_nopop", 32'(pop_head), 0);
      tick();
    end
    chk("t2_req4", 32'(dc_wr_req), 1);
    dc_wr_gnt = 1'b1; dc_wr_done = 1'b0;
    tick();
    dc_wr_gnt = 1'b0;
    chk("t2_wait_req", 32'(dc_wr_req), 0);
    chk("t2_wait_idle", 32'(drain_idle), 0);
    tick();
    chk("t2_wait2_pop", 32'(pop_head), 0);
    dc_wr_done = 1'b1;
    tick();
    dc_wr_done = 1'b0;
    chk("t2_pop", 32'(pop_head), 1);
    chk("t2_scnt", 32'(store_count), 2);
    chk("t2_pop_idle", 32'(drain_idle), 0);
    tick();
    chk("t2_pop_end", 32'(pop_head), 0);

    // Timeout reissue every 4 WAIT cycles; done coinciding with timeout wins
    dc_wr_gnt = 1'b1; dc_wr_done = 1'b0;
    head_valid = 1'b1; head_addr = 16'h0A00; head_data = 16'h0A0A;
    tick();
    head_valid = 1'b0;
    chk("t3_req", 32'(dc_wr_req), 1);
    tick();
    for (int r = 1; r <= 3; r++) begin
      chk("t3_wait_req", 32'(dc_wr_req), 0);
      repeat (3) tick();
      chk("t3_wait_end_req", 32'(dc_wr_req), 0);
      tick();
      chk("t3_reissue", 32'(dc_wr_req), 1);
      chk("t3_retry", 32'(retry_count), 32'(r));
      chk("t3_readdr", 32'(dc_wr_addr), 32'h0A00);
      tick();
    end
    repeat (3) tick();
    chk("t3_last_wait", 32'(dc_wr_req), 0);
    dc_wr_done = 1'b1;
    tick();
    dc_wr_done = 1'b0; dc_wr_gnt = 1'b0;
    chk("t3_pop", 32'(pop_head), 1);
    chk("t3_retry_keep", 32'(retry_count), 3);
    chk("t3_noreq", 32'(dc_wr_req), 0);
    chk("t3_scnt", 32'(store_count), 3);
    tick();
    chk("t3_single_pop", 32'(pop_head), 0);

    // Back-to-back stores with instant ack: pops 3 cycles apart, no issue from POP
    dc_wr_gnt = 1'b1; dc_wr_done = 1'b1;
    head_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      head_addr = 16'(16'h0010 + i); head_data = 16'(16'hD010 + i);
      tick();
      chk("t4_req", 32'(dc_wr_req), 1);
      chk("t4_addr", 32'(dc_wr_addr), 32'(16'h0010 + i));
      chk("t4_data", 32'(dc_wr_data), 32'(16'hD010 + i));
      tick();
      chk("t4_pop", 32'(pop_head), 1);
      chk("t4_scnt", 32'(store_count), 32'(4 + i));
      tick();
      chk("t4_idle_pop", 32'(pop_head), 0);
      chk("t4_idle_req", 32'(dc_wr_req), 0);
      chk("t4_idle", 32'(drain_idle), 1);
    end
    head_valid = 1'b0; dc_wr_gnt = 1'b0; dc_wr_done = 1'b0;
    tick();

    // hold blocks issue in IDLE but not an in-flight store
    hold = 1'b1; head_valid = 1'b1; head_addr = 16'h2222; head_data = 16'h2D2D;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_req", 32'(dc_wr_req), 0);
      chk("t5_hold_idle", 32'(drain_idle), 1);
    end
    hold = 1'b0;
    tick();
    chk("t5_req", 32'(dc_wr_req), 1);
    chk("t5_addr", 32'(dc_wr_addr), 32'h2222);
    dc_wr_gnt = 1'b1;
    tick();
    dc_wr_gnt = 1'b0; hold = 1'b1;
    chk("t5_wait_req", 32'(dc_wr_req), 0);
    tick();
    dc_wr_done = 1'b1;
    tick();
    dc_wr_done = 1'b0;
    chk("t5_pop", 32'(pop_head), 1);
    chk("t5_scnt", 32'(store_count), 7);
    tick(); tick();
    chk("t5_hold_again", 32'(dc_wr_req), 0);
    chk("t5_nopop", 32'(pop_head), 0);
    hold = 1'b0; head_valid = 1'b0;
    tick();

    // Reset while in WAIT
    dc_wr_gnt = 1'b1; head_valid = 1'b1; head_addr = 16'h3333; head_data = 16'h4444;
    tick();
    head_valid = 1'b0;
    tick();
    tick();
    chk("t6_in_wait", 32'(drain_idle), 0);
    RST = 1'b1;
    tick();
    RST = 1'b0; dc_wr_gnt = 1'b0;
    chk("t6_idle", 32'(drain_idle), 1);
    chk("t6_req", 32'(dc_wr_req), 0);
    chk("t6_pop", 32'(pop_head), 0);
    chk("t6_scnt", 32'(store_count), 0);
    chk("t6_rcnt", 32'(retry_count), 0);
    tick();
    chk("t6_post_pop", 32'(pop_head), 0);
    chk("t6_post_idle", 32'(drain_idle), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
